// File: rtl/analog_mux4_scan_ctrl_if.sv
// Bundle between the scan controller and the core / analog mux / ADC side.
// The controller takes the master view; the surrounding logic takes the slave view.
interface analog_mux4_scan_ctrl_if #(
    parameter int unsigned ADC_W = 10
);
    logic             start;
    logic             enable;
    logic             single;
    logic [3:0]       chan_mask;
    logic [7:0]       settle;
    logic [1:0]       SEL;
    logic             mux_en;
    logic             adc_start;
    logic             adc_done;
    logic [ADC_W-1:0] adc_data;
    logic [1:0]       rd_chan;
    logic [ADC_W-1:0] rd_data;
    logic [3:0]       valid;
    logic             busy;
    logic             done;
    logic             timeout_err;

    modport master (
        input  start, enable, single, chan_mask, settle, adc_done, adc_data, rd_chan,
        output SEL, mux_en, adc_start, rd_data, valid, busy, done, timeout_err
    );

    modport slave (
        output start, enable, single, chan_mask, settle, adc_done, adc_data, rd_chan,
        input  SEL, mux_en, adc_start, rd_data, valid, busy, done, timeout_err
    );
endinterface

// File: rtl/analog_mux4_scan_ctrl.sv
// Scan sequencer for a 4-input analog mux feeding an ADC. Walks the channel mask with
// break-before-make switching, waits a programmable settle time, runs one conversion per
// channel and stores each result in a per-channel register.
module analog_mux4_scan_ctrl #(
    parameter int unsigned ADC_W   = 10,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic                     clk,
    input logic                     reset,
    analog_mux4_scan_ctrl_if.master bus
);

    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StBreak, StSettle, StConvert, StNext} state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             mux_en_q, mux_en_d;
    logic [7:0]       settle_cnt_q, settle_cnt_d;
    // Cycles elapsed since adc_start; zero marks the adc_start cycle itself.
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [ADC_W-1:0] result_q [4];
    logic [ADC_W-1:0] result_d [4];
    logic [3:0]       valid_q, valid_d;
    logic             tmo_err_q, tmo_err_d;
    logic             done_q, done_d;

    // Lowest set bit of mask at index >= lo; bit 2 of the result flags a hit.
    function automatic logic [2:0] scan_from(input logic [3:0] mask, input int lo);
        logic [2:0] hit;
        hit = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[2'(i)] && (i >= lo)) hit = {1'b1, 2'(i)};
        end
        return hit;
    endfunction

    logic [2:0] first_hit, next_hit;
    assign first_hit = scan_from(bus.chan_mask, 0);
    assign next_hit  = scan_from(bus.chan_mask, int'(sel_q) + 1);

    // Next-state and datapath updates; an abort overrides every non-idle state.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        mux_en_d     = mux_en_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        result_d     = result_q;
        valid_d      = valid_q;
        tmo_err_d    = tmo_err_q;
        done_d       = 1'b0;

        if ((state_q != StIdle) && !bus.enable) begin
            state_d  = StIdle;
            mux_en_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && bus.enable && (bus.chan_mask != 4'b0000)) begin
                        sel_d     = first_hit[1:0];
                        mux_en_d  = 1'b0;
                        valid_d   = 4'b0000;
                        tmo_err_d = 1'b0;
                        state_d   = StBreak;
                    end
                end
                StBreak: begin
                    settle_cnt_d = (bus.settle == 8'd0) ? 8'd1 : bus.settle;
                    mux_en_d     = 1'b1;
                    state_d      = StSettle;
                end
                StSettle: begin
                    if (settle_cnt_q <= 8'd1) begin
                        tmo_cnt_d = '0;
                        state_d   = StConvert;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 8'd1;
                    end
                end
                StConvert: begin
                    if ((tmo_cnt_q != '0) && bus.adc_done) begin
                        result_d[sel_q] = bus.adc_data;
                        valid_d[sel_q]  = 1'b1;
                        state_d         = StNext;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_err_d = 1'b1;
                        state_d   = StNext;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
                StNext: begin
                    if (bus.chan_mask == 4'b0000) begin
                        state_d = StIdle;
                    end else if (next_hit[2]) begin
                        sel_d    = next_hit[1:0];
                        mux_en_d = 1'b0;
                        state_d  = StBreak;
                    end else if (bus.single) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        sel_d    = first_hit[1:0];
                        mux_en_d = 1'b0;
                        state_d  = StBreak;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            sel_q        <= 2'b00;
            mux_en_q     <= 1'b0;
            settle_cnt_q <= 8'd0;
            tmo_cnt_q    <= '0;
            result_q     <= '{default: '0};
            valid_q      <= 4'b0000;
            tmo_err_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            mux_en_q     <= mux_en_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            tmo_err_q    <= tmo_err_d;
            done_q       <= done_d;
        end
    end

    assign bus.SEL         = sel_q;
    assign bus.mux_en      = mux_en_q;
    assign bus.adc_start   = (state_q == StConvert) && (tmo_cnt_q == '0);
    assign bus.rd_data     = result_q[bus.rd_chan];
    assign bus.valid       = valid_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_analog_mux4_scan_ctrl.sv
// Bench for analog_mux4_scan_ctrl: a phase/age reference model checked every cycle, an ADC
// responder, and directed scenarios with hand-computed timing and data expectations.
module tb_analog_mux4_scan_ctrl;

    localparam int ADC_W   = 10;
    localparam int TIMEOUT = 16;

    localparam int P_IDLE  = 0;
    localparam int P_BRK   = 1;
    localparam int P_SET   = 2;
    localparam int P_CONV  = 3;
    localparam int P_NXT   = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    analog_mux4_scan_ctrl_if #(.ADC_W(ADC_W)) bus ();

    analog_mux4_scan_ctrl #(
        .ADC_W   (ADC_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int               ph = P_IDLE;
    int               age = 0;
    int               hold = 1;
    int               nx;
    logic [1:0]       m_sel = 2'b00;
    logic             m_mux = 1'b0;
    logic             m_done = 1'b0;
    logic [3:0]       m_valid = 4'b0000;
    logic             m_terr = 1'b0;
    logic [ADC_W-1:0] m_res [4];

    function automatic int next_above(input logic [3:0] m, input int cur);
        for (int c = 0; c < 4; c++) begin
            if ((c > cur) && m[2'(c)]) return c;
        end
        return -1;
    endfunction

    // Model: phase plus cycles-in-phase, channel order from the live mask.
    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        if (reset) begin
            ph = P_IDLE; age = 0; m_sel = 2'b00; m_mux = 1'b0; m_valid = 4'b0000;
            m_terr = 1'b0;
            for (int k = 0; k < 4; k++) m_res[k] = '0;
        end else if ((ph != P_IDLE) && !bus.enable) begin
            ph = P_IDLE;
            m_mux = 1'b0;
        end else begin
            case (ph)
                P_IDLE: if (bus.start && (bus.chan_mask != 4'b0000)) begin
                    m_sel = 2'(next_above(bus.chan_mask, -1));
                    m_mux = 1'b0; m_valid = 4'b0000; m_terr = 1'b0; ph = P_BRK;
                end
                P_BRK: begin
                    hold = (bus.settle == 8'd0) ? 1 : int'(bus.settle);
                    m_mux = 1'b1; ph = P_SET; age = 0;
                end
                P_SET: begin
                    if (age == hold - 1) begin ph = P_CONV; age = 0; end
                    else age++;
                end
                P_CONV: begin
                    if ((age > 0) && bus.adc_done) begin
                        m_res[m_sel] = bus.adc_data; m_valid[m_sel] = 1'b1; ph = P_NXT;
                    end else if (age == TIMEOUT - 1) begin
                        m_terr = 1'b1; ph = P_NXT;
                    end else age++;
                end
                default: begin
                    if (bus.chan_mask == 4'b0000) ph = P_IDLE;
                    else begin
                        nx = next_above(bus.chan_mask, int'(m_sel));
                        if ((nx < 0) && bus.single) begin
                            ph = P_IDLE; m_done = 1'b1;
                        end else begin
                            if (nx < 0) nx = next_above(bus.chan_mask, -1);
                            m_sel = 2'(nx); m_mux = 1'b0; ph = P_BRK;
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("SEL", 32'(bus.SEL), 32'(m_sel));
            check("mux_en", 32'(bus.mux_en), 32'(m_mux));
            check("adc_start", 32'(bus.adc_start), 32'((ph == P_CONV) && (age == 0)));
            check("busy", 32'(bus.busy), 32'(ph != P_IDLE));
            check("done", 32'(bus.done), 32'(m_done));
            check("valid", 32'(bus.valid), 32'(m_valid));
            check("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
            check("rd_data", 32'(bus.rd_data), 32'(m_res[bus.rd_chan]));
        end
    end

    // ---------------- event monitor ----------------
    int   break_cyc[$];
    int   break_sel[$];
    int   start_cyc[$];
    int   terr_rise[$];
    int   done_cnt = 0;
    logic terr_prev = 1'b0;

    // Logs break cycles, conversion requests, done pulses and timeout rises.
    always @(negedge clk) begin
        if (bus.busy === 1'b1 && bus.mux_en === 1'b0) begin
            break_cyc.push_back(cyc);
            break_sel.push_back(int'(bus.SEL));
        end
        if (bus.adc_start === 1'b1) start_cyc.push_back(cyc);
        if (bus.done === 1'b1) done_cnt++;
        if (bus.timeout_err === 1'b1 && terr_prev !== 1'b1) terr_rise.push_back(cyc);
        terr_prev = bus.timeout_err;
    end

    // ---------------- ADC responder ----------------
    int adc_lat = 0;
    int adc_cnt = 0;
    int adc_vals[$];
    int adc_rd = 0;
    int poke_req = 0;
    int poke_ack = 0;

    // Answers adc_start after adc_lat cycles; a poke forces a stray adc_done this cycle.
    initial begin
        bus.adc_done = 1'b0;
        bus.adc_data = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.adc_done = 1'b0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    bus.adc_done = 1'b1;
                    bus.adc_data = (adc_rd < adc_vals.size()) ? ADC_W'(adc_vals[adc_rd]) : '0;
                    adc_rd++;
                end
            end
            if (bus.adc_start === 1'b1 && adc_lat > 0) adc_cnt = adc_lat;
            if (poke_req != poke_ack) begin
                bus.adc_done = 1'b1;
                bus.adc_data = ADC_W'(10'h3FF);
                poke_ack = poke_req;
            end
        end
    end

    task automatic pulse_start(output int t);
        bus.start = 1'b1;
        t = cyc;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    task automatic read_res(input logic [1:0] ch, input string name, input int want);
        bus.rd_chan = ch;
        #1;
        check(name, 32'(bus.rd_data), want);
    endtask

    int t0, b_brk, b_st, b_done, b_terr, n;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.enable = 1'b0; bus.single = 1'b1;
        bus.chan_mask = 4'b0000; bus.settle = 8'd0; bus.rd_chan = 2'b00;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        reset = 1'b0;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_sel", 32'(bus.SEL), 0);
        check("rst_mux_en", 32'(bus.mux_en), 0);
        check("rst_valid", 32'(bus.valid), 0);

        // Single pass over 1010, settle 3, ADC answers after 5 cycles.
        bus.enable = 1'b1; bus.chan_mask = 4'b1010; bus.settle = 8'd3; bus.single = 1'b1;
        adc_lat = 5; adc_vals.push_back(10'h155); adc_vals.push_back(10'h2AA);
        b_brk = break_cyc.size(); b_st = start_cyc.size(); b_done = done_cnt;
        pulse_start(t0);
        wait_idle(200, "t1_idle");
        check("t1_done_at_idle", 32'(bus.done), 1);
        tick(1);
        check("t1_done_one_cycle", 32'(bus.done), 0);
        check("t1_break_count", break_cyc.size() - b_brk, 2);
        check("t1_sel_first", break_sel[b_brk], 1);
        check("t1_sel_second", break_sel[b_brk + 1], 3);
        check("t1_break_lat", break_cyc[b_brk] - t0, 1);
        check("t1_start_lat0", start_cyc[b_st] - break_cyc[b_brk], 4);
        check("t1_start_lat1", start_cyc[b_st + 1] - break_cyc[b_brk + 1], 4);
        check("t1_next_break", break_cyc[b_brk + 1] - start_cyc[b_st], 7);
        check("t1_valid", 32'(bus.valid), 32'b1010);
        check("t1_done_cnt", done_cnt - b_done, 1);
        check("t1_mux_hold", 32'(bus.mux_en), 1);
        check("t1_sel_hold", 32'(bus.SEL), 3);
        read_res(2'd1, "t1_res1", 10'h155);
        read_res(2'd3, "t1_res3", 10'h2AA);

        // Continuous scan over 0101, then abort in SETTLE.
        bus.chan_mask = 4'b0101; bus.settle = 8'd2; bus.single = 1'b0; adc_lat = 3;
        adc_vals.push_back(10'h011); adc_vals.push_back(10'h022);
        adc_vals.push_back(10'h033); adc_vals.push_back(10'h044);
        b_brk = break_cyc.size(); b_st = start_cyc.size(); b_done = done_cnt;
        pulse_start(t0);
        n = 0;
        while ((break_cyc.size() - b_brk) < 5 && n < 300) begin
            tick(1);
            n++;
        end
        check("t2_reached_5_breaks", 32'((break_cyc.size() - b_brk) >= 5), 1);
        bus.enable = 1'b0;
        tick(1);
        check("t2_abort_busy", 32'(bus.busy), 0);
        check("t2_abort_mux", 32'(bus.mux_en), 0);
        check("t2_abort_sel", 32'(bus.SEL), 0);
        tick(3);
        check("t2_sel0", break_sel[b_brk], 0);
        check("t2_sel1", break_sel[b_brk + 1], 2);
        check("t2_sel2", break_sel[b_brk + 2], 0);
        check("t2_sel3", break_sel[b_brk + 3], 2);
        check("t2_no_done", done_cnt - b_done, 0);
        check("t2_conversions", start_cyc.size() - b_st, 4);
        check("t2_valid", 32'(bus.valid), 32'b0101);
        read_res(2'd0, "t2_res0", 10'h033);
        read_res(2'd2, "t2_res2", 10'h044);

        // Timeout on a silent ADC.
        bus.enable = 1'b1; bus.chan_mask = 4'b0001; bus.settle = 8'd1; bus.single = 1'b1;
        adc_lat = 0;
        b_st = start_cyc.size(); b_done = done_cnt; b_terr = terr_rise.size();
        pulse_start(t0);
        wait_idle(100, "t3_idle");
        tick(1);
        check("t3_terr_rise", terr_rise.size() - b_terr, 1);
        check("t3_terr_lat", terr_rise[b_terr] - start_cyc[b_st], TIMEOUT);
        check("t3_timeout_err", 32'(bus.timeout_err), 1);
        check("t3_valid", 32'(bus.valid), 0);
        check("t3_done_cnt", done_cnt - b_done, 1);

        // settle=0 acts as 1; adc_done in the adc_start cycle is ignored.
        bus.chan_mask = 4'b0100; bus.settle = 8'd0; adc_lat = 5;
        adc_vals.push_back(10'h0AB);
        b_st = start_cyc.size(); b_done = done_cnt;
        pulse_start(t0);
        tick(2);
        poke_req++;
        wait_idle(100, "t4_idle");
        tick(1);
        check("t4_start_lat", start_cyc[b_st] - t0, 3);
        check("t4_conversions", start_cyc.size() - b_st, 1);
        check("t4_valid", 32'(bus.valid), 32'b0100);
        check("t4_terr_cleared", 32'(bus.timeout_err), 0);
        read_res(2'd2, "t4_res2", 10'h0AB);

        // start with an empty mask is ignored.
        bus.chan_mask = 4'b0000;
        b_brk = break_cyc.size();
        pulse_start(t0);
        tick(2);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_no_break", break_cyc.size() - b_brk, 0);

        // Mask cleared mid-scan: IDLE at NEXT without done.
        bus.chan_mask = 4'b0011; bus.settle = 8'd1; adc_lat = 4;
        adc_vals.push_back(10'h1C3);
        b_brk = break_cyc.size(); b_st = start_cyc.size(); b_done = done_cnt;
        pulse_start(t0);
        n = 0;
        while (start_cyc.size() == b_st && n < 50) begin
            tick(1);
            n++;
        end
        bus.chan_mask = 4'b0000;
        wait_idle(50, "t6_idle");
        tick(1);
        check("t6_no_done", done_cnt - b_done, 0);
        check("t6_breaks", break_cyc.size() - b_brk, 1);
        check("t6_valid", 32'(bus.valid), 32'b0001);
        read_res(2'd0, "t6_res0", 10'h1C3);

        // Reset asserted mid-CONVERT.
        bus.chan_mask = 4'b1000; adc_lat = 0; bus.rd_chan = 2'd0;
        b_st = start_cyc.size();
        pulse_start(t0);
        n = 0;
        while (start_cyc.size() == b_st && n < 50) begin
            tick(1);
            n++;
        end
        check("t7_in_convert", 32'(bus.busy), 1);
        reset = 1'b1;
        tick(1);
        check("t7_sel", 32'(bus.SEL), 0);
        check("t7_mux_en", 32'(bus.mux_en), 0);
        check("t7_busy", 32'(bus.busy), 0);
        check("t7_valid", 32'(bus.valid), 0);
        check("t7_res0", 32'(bus.rd_data), 0);
        reset = 1'b0;
        tick(3);
        check("t7_stay_idle", 32'(bus.busy), 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
